vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 132 +++++++++++++
 tb/tb_vga_timing.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : VGA raster timing generator: pixel strobe, x/y counters and
//            zero-skew registered sync/blanking. The optional frame counter is
//            enabled with macro VGA_TIMING_FRAME_CNT_EN.
// Revision : 1.0
// ============================================================================
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_stb,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       display_en,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  c_div_last = 4'(PIX_DIV - 1);
  localparam logic [9:0]  c_x_last   = 10'(c_h_total - 1);
  localparam logic [9:0]  c_y_last   = 10'(c_v_total - 1);
  // 11-bit bounds so an end-of-pulse equal to 1024 still compares correctly
  localparam logic [10:0] c_h_act    = 11'(H_ACTIVE);
  localparam logic [10:0] c_v_act    = 11'(V_ACTIVE);
  localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_pix_stb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_de;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_frame_wrap;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;

  assign w_tick       = (r_div == c_div_last);
  assign w_x_last     = (r_x == c_x_last);
  assign w_y_last     = (r_y == c_y_last);
  assign w_frame_wrap = w_tick & w_x_last & w_y_last;

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_tick) begin
      if (w_x_last) begin
        w_x_next = 10'd0;
        w_y_next = w_y_last ? 10'd0 : r_y + 10'd1;
      end else begin
        w_x_next = r_x + 10'd1;
      end
    end
  end

  assign w_x_ext = {1'b0, w_x_next};
  assign w_y_ext = {1'b0, w_y_next};

  // Sync/blank decoded from next-state counters so they land with x/y
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= 4'd0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_pix_stb     <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? 4'd0 : r_div + 4'd1;
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_pix_stb     <= w_tick;
      r_hsync       <= !((w_x_ext >= c_hs_start) && (w_x_ext < c_hs_end));
      r_vsync       <= !((w_y_ext >= c_vs_start) && (w_y_ext < c_vs_end));
      r_de          <= (w_x_ext < c_h_act) && (w_y_ext < c_v_act);
      r_frame_start <= w_frame_wrap;
    end
  end

  assign pix_stb     = r_pix_stb;
  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_en  = r_de;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_count = r_frame_cnt;
`else
  assign frame_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// Bench for vga_timing: a default-parameter instance (PIX_DIV=2) and a small
// fast raster instance (PIX_DIV=1), each followed by a closed-form scoreboard.
module tb_vga_timing;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct packed {
    logic       stb;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   x;
    int   y;   // -1: any line
    logic hs;
    logic vs;
    logic de;
  } vec_t;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic       d_stb, d_de, d_hs, d_vs, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_stb, s_de, s_hs, s_vs, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_timing dut_d (
    .clk(clk), .reset(rst_d), .pix_stb(d_stb), .x(d_x), .y(d_y),
    .display_en(d_de), .hsync(d_hs), .vsync(d_vs),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(1)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pix_stb(s_stb), .x(s_x), .y(s_y),
    .display_en(s_de), .hsync(s_hs), .vsync(s_vs),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  // Closed form: n = clk edges since reset released
  function automatic obs_t model(input int n, input int dv,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb);
    obs_t o;
    int ht, vt, p, xi, yi;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = n / dv;
    xi = p % ht;
    yi = (p / ht) % vt;
    o.stb = (n > 0) && (n % dv == 0);
    o.x   = 10'(xi);
    o.y   = 10'(yi);
    o.de  = (xi < ha) && (yi < va);
    o.hs  = !((xi >= ha + hf) && (xi < ha + hf + hsw));
    o.vs  = !((yi >= va + vf) && (yi < va + vf + vsw));
    o.fs  = o.stb && (xi == 0) && (yi == 0);
    o.fc  = FC_EN ? 8'((p / (ht * vt)) % 256) : 8'd0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  obs_t q_d[$];
  obs_t q_s[$];

  initial begin : sb_d
    int n;
    obs_t e, a;
    n = 0;
    forever begin
      @(posedge clk);
      n = rst_d ? 0 : n + 1;
      q_d.push_back(model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      #1;
      e = q_d.pop_front();
      a = obs_t'({d_stb, d_x, d_y, d_de, d_hs, d_vs, d_fs, d_fc});
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_default t=%0t actual=%h expected=%h", $time, a, e);
      end
    end
  end

  initial begin : sb_s
    int n;
    obs_t e, a;
    n = 0;
    forever begin
      @(posedge clk);
      n = rst_s ? 0 : n + 1;
      q_s.push_back(model(n, 1, 8, 2, 3, 3, 4, 1, 2, 1));
      #1;
      e = q_s.pop_front();
      a = obs_t'({s_stb, s_x, s_y, s_de, s_hs, s_vs, s_fs, s_fc});
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_small t=%0t actual=%h expected=%h", $time, a, e);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t hv[8];
    vec_t vv[7];
    bit   found;
    int   t0, nfs;

    hv[0] = '{639, -1, 1'b1, 1'b1, 1'b1};
    hv[1] = '{640, -1, 1'b1, 1'b1, 1'b0};
    hv[2] = '{655, -1, 1'b1, 1'b1, 1'b0};
    hv[3] = '{656, -1, 1'b0, 1'b1, 1'b0};
    hv[4] = '{751, -1, 1'b0, 1'b1, 1'b0};
    hv[5] = '{752, -1, 1'b1, 1'b1, 1'b0};
    hv[6] = '{799, -1, 1'b1, 1'b1, 1'b0};
    hv[7] = '{0,   -1, 1'b1, 1'b1, 1'b1};

    vv[0] = '{0,  3, 1'b1, 1'b1, 1'b1};
    vv[1] = '{0,  4, 1'b1, 1'b1, 1'b0};
    vv[2] = '{0,  5, 1'b1, 1'b0, 1'b0};
    vv[3] = '{12, 6, 1'b0, 1'b0, 1'b0};
    vv[4] = '{0,  7, 1'b1, 1'b1, 1'b0};
    vv[5] = '{7,  0, 1'b1, 1'b1, 1'b1};
    vv[6] = '{8,  0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_x", 32'(d_x), 0);
    chk("rst_y", 32'(d_y), 0);
    chk("rst_sync_de", {d_hs, d_vs, d_de}, 3'b111);
    chk("rst_stb_fs_fc", {d_stb, d_fs, d_fc}, 0);
    chk("rst_small_xy", {s_x, s_y}, 0);

    rst_d = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    chk("rel1_x", 32'(d_x), 0);
    chk("rel1_stb", 32'(d_stb), 0);
    @(negedge clk);
    chk("rel2_x", 32'(d_x), 1);
    chk("rel2_stb", 32'(d_stb), 1);

    // Horizontal boundaries on the default raster
    for (int i = 0; i < 8; i++) begin
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (d_stb && d_x == 10'(hv[i].x)) begin found = 1'b1; break; end
      end
      chk($sformatf("hvec%0d_found", i), 32'(found), 1);
      chk($sformatf("hvec%0d_x%0d_hs_vs_de", i, hv[i].x),
          {d_hs, d_vs, d_de}, {hv[i].hs, hv[i].vs, hv[i].de});
    end

    // Line period: consecutive x=0 strobes
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (d_stb && d_x == 10'd0) begin found = 1'b1; break; end
    end
    t0 = cyc;
    @(negedge clk);
    for (int k = 0; k < 2000 && !(d_stb && d_x == 10'd0); k++) @(negedge clk);
    chk("line_found", 32'(found), 1);
    chk("line_period", 32'(cyc - t0), 1600);

    // Mid-line reset on the default raster
    for (int k = 0; k < 2000 && d_x != 10'd700; k++) @(negedge clk);
    chk("d_at_700", 32'(d_x), 700);
    rst_d = 1'b1;
    @(negedge clk);
    chk("d_midrst_xy", {d_x, d_y}, 0);
    chk("d_midrst_hs_vs_fc", {d_hs, d_vs, d_fc}, {2'b11, 8'd0});
    rst_d = 1'b0;
    @(negedge clk);
    chk("d_midrel1_x", 32'(d_x), 0);
    @(negedge clk);
    chk("d_midrel2_x", 32'(d_x), 1);

    // Vertical boundaries on the small raster
    for (int i = 0; i < 7; i++) begin
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (s_stb && s_x == 10'(vv[i].x) && s_y == 10'(vv[i].y)) begin found = 1'b1; break; end
      end
      chk($sformatf("vvec%0d_found", i), 32'(found), 1);
      chk($sformatf("vvec%0d_x%0d_y%0d_hs_vs_de", i, vv[i].x, vv[i].y),
          {s_hs, s_vs, s_de}, {vv[i].hs, vv[i].vs, vv[i].de});
    end

    // Frame period and coincident x/y wrap
    for (int k = 0; k < 300 && !s_fs; k++) @(negedge clk);
    t0 = cyc;
    chk("fs_xy", {s_fs, s_x, s_y}, {1'b1, 20'd0});
    @(negedge clk);
    for (int k = 0; k < 300 && !s_fs; k++) @(negedge clk);
    chk("frame_period", 32'(cyc - t0), 128);

    // Mid-frame reset on the small raster, inside vsync
    for (int k = 0; k < 300 && !(s_x == 10'd10 && s_y == 10'd5); k++) @(negedge clk);
    chk("s_at_10_5", {s_x, s_y}, {10'd10, 10'd5});
    rst_s = 1'b1;
    @(negedge clk);
    chk("s_midrst", {s_x, s_y, s_hs, s_vs, s_fc}, {20'd0, 2'b11, 8'd0});
    rst_s = 1'b0;
    @(negedge clk);
    chk("s_midrel1_x", 32'(s_x), 1);

    // 257 frames after reset
    nfs = 0;
    for (int k = 0; k < 257 * 128 + 500 && nfs < 257; k++) begin
      @(negedge clk);
      if (s_fs) nfs++;
    end
    chk("frames_seen", 32'(nfs), 257);
    chk("frame_count_257", 32'(s_fc), FC_EN ? 1 : 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
